mmio_out_bank: RTL and testbench
================================

MMIO_OUT_BANK -- requirements
Module: mmio_out_bank

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 15'h7000, first bus address of the bank, multiple of 4.
REQ-002 SHALL have parameter AW, default 15, address width.
REQ-003 SHALL have parameter DW, default 16, data width.
REQ-004 SHALL have parameter NCH, default 4, output channel count, 1..16.
REQ-005 SHALL have parameter PULSE_LEN, default 50000, pulse duration in clk50m cycles, >= 1.
REQ-006 SHALL have port clk50m, input, 1, the single clock (rising edge).
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port addr, input, AW, bus address.
REQ-009 SHALL have port data_in, input, DW, write data / mask.
REQ-010 SHALL have port we, input, 1, write enable, sampled on rising clk50m edge.
REQ-011 SHALL have port data_out, output, NCH x DW packed, per-channel output register.
REQ-012 SHALL have port busy, output, NCH, per-channel pulse active flag.
REQ-013 SHALL have port rd_data, output, DW, registered readback of the addressed channel.
REQ-014 SHALL have port hit, output, 1, registered flag: addr was inside the bank.

Function
REQ-015 SHALL decode channel c = (addr-BASE_ADDR)>>2 and op = addr[1:0] when BASE_ADDR <= addr < BASE_ADDR+4*NCH; any other addr is out of range.
REQ-016 SHALL apply op on a write to channel c: 0 WRITE (data_out[c] <= data_in), 1 SET (data_out[c] | data_in), 2 CLR (data_out[c] & ~data_in), 3 PULSE.
REQ-017 SHALL, on PULSE, load data_out[c] <= data_in and its counter <= PULSE_LEN, and assert busy[c] from the next cycle.
REQ-018 SHALL decrement an active channel's counter every cycle, hold data_out[c] for exactly PULSE_LEN cycles, then set data_out[c] to 0 and deassert busy[c] on the same edge.
REQ-019 SHALL make a PULSE during an active pulse reload both data and counter (retrigger).
REQ-020 SHALL make a WRITE/SET/CLR during an active pulse cancel it (busy[c] <= 0) and apply the op to the current value.
REQ-021 SHALL give a write precedence when a write and pulse expiry coincide on the same channel and edge.
REQ-022 SHALL ignore writes that are out of range and writes with we=0; all channels hold their state.
REQ-023 SHALL update rd_data <= data_out[c] and hit <= 1 one cycle after any in-range addr, independent of we; out of range gives rd_data <= 0, hit <= 0.
REQ-024 SHALL size the counter as $clog2(PULSE_LEN+1) bits so there is no wrap-around.
REQ-025 SHALL leave channels other than c unaffected by any write to c.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force data_out, busy, rd_data, hit and all counters to 0, including mid-pulse.
REQ-027 SHALL resume normal operation on the first rising clk50m edge after rst_n deasserts, with no pending pulse.

Structure
REQ-028 SHALL place the op encoding (enum WRITE/SET/CLR/PULSE) and the 2-bit op field width in a shared package mmio_pkg.
REQ-029 SHALL implement one channel (register, counter, busy) as sub-module mmio_out_chan, instantiated NCH times in a generate loop.
REQ-030 SHALL keep decode and readback mux in mmio_out_bank.

Verification
REQ-031 SHALL cover this scenario: reset, WRITE 0x7004 <- 16'hA5A5, then read 0x7004 -> data_out[1]=A5A5 after 1 edge, rd_data=A5A5 and hit=1 one cycle after the read address.
REQ-032 SHALL cover this scenario: SET 0x7001 <- 00F0 on data 0F00, then CLR 0x7002 <- 0300 -> data_out[0]=0FF0, then 0CF0.
REQ-033 SHALL cover this scenario: PULSE_LEN=5, PULSE 0x700B <- 0001 -> data_out[2]=1 and busy[2]=1 for exactly 5 cycles, then 0; retrigger at cycle 3 -> 5 more cycles from retrigger.
REQ-034 SHALL cover this scenario: WRITE to the pulsing channel on the expiry edge -> busy=0, data_out = written value (write wins).
REQ-035 SHALL cover this scenario: we=1 at addr 0x7010 (NCH=4) and 0x6FFF -> no data_out change, hit=0, rd_data=0.
REQ-036 SHALL cover this scenario: rst_n=0 asynchronously mid-pulse -> all outputs 0 immediately, no pulse resumes after release.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared MMIO output-bank definitions: op encoding carried in addr[1:0].
// Pure types/constants; no logic, no latency, no flow control.
package mmio_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_WRITE = 2'd0,
        OP_SET   = 2'd1,
        OP_CLR   = 2'd2,
        OP_PULSE = 2'd3
    } mmio_op_e;

    // Counter must hold PULSE_LEN itself, so size for PULSE_LEN+1 states.
    function automatic int cnt_width(input int plen);
        return (plen < 1) ? 1 : $clog2(plen + 1);
    endfunction

endpackage

// File: rtl/mmio_out_chan.sv
// One output channel: data register, pulse down-counter and busy flag.
// Latency: ops take effect on the next clk50m edge. No backpressure; writes always accepted.
module mmio_out_chan
    import mmio_pkg::*;
#(
    parameter int DW        = 16,
    parameter int PULSE_LEN = 50000
) (
    input  logic          clk50m,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  mmio_op_e      op_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic          busy_o
);

    localparam int                 CNT_W    = cnt_width(PULSE_LEN);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(PULSE_LEN);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    logic [DW-1:0]    data_q, data_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             busy_q, busy_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;

        if (busy_q) begin
            if (cnt_q <= CNT_ONE) begin
                data_d = '0;
                cnt_d  = '0;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end

        // A write overrides expiry and works on the pre-edge register value.
        if (wr_en_i) begin
            cnt_d  = '0;
            busy_d = 1'b0;
            unique case (op_i)
                OP_WRITE: data_d = data_i;
                OP_SET:   data_d = data_q | data_i;
                OP_CLR:   data_d = data_q & ~data_i;
                OP_PULSE: begin
                    data_d = data_i;
                    cnt_d  = CNT_LOAD;
                    busy_d = 1'b1;
                end
                default:  data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign data_o = data_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/mmio_out_bank.sv
// Bank of NCH memory-mapped output channels with write/set/clear/pulse ops and registered readback.
// Latency: writes and readback both land one clk50m edge after the address. No backpressure.
module mmio_out_bank
    import mmio_pkg::*;
#(
    parameter int            AW        = 15,
    parameter logic [AW-1:0] BASE_ADDR = 15'h7000,
    parameter int            DW        = 16,
    parameter int            NCH       = 4,
    parameter int            PULSE_LEN = 50000
) (
    input  logic                    clk50m,
    input  logic                    rst_n,
    input  logic [AW-1:0]           addr,
    input  logic [DW-1:0]           data_in,
    input  logic                    we,
    output logic [NCH-1:0][DW-1:0]  data_out,
    output logic [NCH-1:0]          busy,
    output logic [DW-1:0]           rd_data,
    output logic                    hit
);

    localparam int          CW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW:0] BASE_EXT = {1'b0, BASE_ADDR};
    localparam logic [AW:0] SPAN     = (AW+1)'(4 * NCH);

    logic [AW:0]   addr_ext;
    logic [AW:0]   offset;
    logic          in_range;
    logic [CW-1:0] chan_idx;
    mmio_op_e      op;

    // One extra bit keeps the subtraction and span compare free of wrap-around.
    assign addr_ext = {1'b0, addr};
    assign offset   = addr_ext - BASE_EXT;
    assign in_range = (addr_ext >= BASE_EXT) && (offset < SPAN);
    assign chan_idx = offset[CW+1:2];
    assign op       = mmio_op_e'(addr[OP_W-1:0]);

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        logic chan_wr;
        assign chan_wr = we && in_range && (chan_idx == CW'(g));

        mmio_out_chan #(
            .DW        (DW),
            .PULSE_LEN (PULSE_LEN)
        ) u_chan (
            .clk50m  (clk50m),
            .rst_n   (rst_n),
            .wr_en_i (chan_wr),
            .op_i    (op),
            .data_i  (data_in),
            .data_o  (data_out[g]),
            .busy_o  (busy[g])
        );
    end

    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          hit_q, hit_d;

    always_comb begin
        rd_data_d = '0;
        hit_d     = 1'b0;
        if (in_range) begin
            rd_data_d = data_out[chan_idx];
            hit_d     = 1'b1;
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
            hit_q     <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            hit_q     <= hit_d;
        end
    end

    assign rd_data = rd_data_q;
    assign hit     = hit_q;

endmodule

// File: tb/tb_mmio_out_bank.sv
// Directed bench for mmio_out_bank: each step queues the hand-computed post-edge state,
// a monitor pops one entry per edge and compares every output.
module tb_mmio_out_bank;

    logic                 clk50m = 1'b0;
    logic                 rst_n  = 1'b0;
    logic [14:0]          addr    = '0;
    logic [15:0]          data_in = '0;
    logic                 we      = 1'b0;
    logic [3:0][15:0]     data_out;
    logic [3:0]           busy;
    logic [15:0]          rd_data;
    logic                 hit;

    mmio_out_bank #(
        .AW        (15),
        .BASE_ADDR (15'h7000),
        .DW        (16),
        .NCH       (4),
        .PULSE_LEN (5)
    ) dut (
        .clk50m   (clk50m),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_in  (data_in),
        .we       (we),
        .data_out (data_out),
        .busy     (busy),
        .rd_data  (rd_data),
        .hit      (hit)
    );

    always #10 clk50m = ~clk50m;

    typedef struct {
        logic [3:0][15:0] d;
        logic [3:0]       b;
        logic [15:0]      rd;
        logic             h;
        int               id;
    } exp_t;

    exp_t e;
    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step   = 0;

    task automatic check_all(input exp_t x);
        for (int ch = 0; ch < 4; ch++) begin
            n_chk++;
            if (data_out[ch] !== x.d[ch]) begin
                n_fail++;
                $display("FAIL step%0d data_out[%0d]: got %h want %h", x.id, ch, data_out[ch], x.d[ch]);
            end
        end
        n_chk++;
        if (busy !== x.b) begin
            n_fail++;
            $display("FAIL step%0d busy: got %b want %b", x.id, busy, x.b);
        end
        n_chk++;
        if (rd_data !== x.rd) begin
            n_fail++;
            $display("FAIL step%0d rd_data: got %h want %h", x.id, rd_data, x.rd);
        end
        n_chk++;
        if (hit !== x.h) begin
            n_fail++;
            $display("FAIL step%0d hit: got %b want %b", x.id, hit, x.h);
        end
    endtask

    // Drive one bus cycle; e must already hold the state expected after this edge.
    task automatic cyc(input logic [14:0] a, input logic [15:0] d, input logic w);
        @(negedge clk50m);
        addr    = a;
        data_in = d;
        we      = w;
        step++;
        e.id = step;
        q.push_back(e);
        @(posedge clk50m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            e.rd = '0;
            e.h  = 1'b0;
            cyc(15'h0000, 16'h0000, 1'b0);
        end
    endtask

    task automatic clear_exp();
        e.d  = '0;
        e.b  = '0;
        e.rd = '0;
        e.h  = 1'b0;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk50m);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check_all(x);
            end
        end
    end

    initial begin : stim
        clear_exp();
        e.id = 0;

        // Reset held: even in-range writes must not disturb anything.
        cyc(15'h7004, 16'hFFFF, 1'b1);
        cyc(15'h7004, 16'hFFFF, 1'b1);
        @(negedge clk50m);
        addr = '0; data_in = '0; we = 1'b0;
        rst_n = 1'b1;

        // WRITE then read back channel 1.
        e.d[1] = 16'hA5A5; e.rd = 16'h0000; e.h = 1'b1;
        cyc(15'h7004, 16'hA5A5, 1'b1);
        e.rd = 16'hA5A5; e.h = 1'b1;
        cyc(15'h7004, 16'h0000, 1'b0);

        // WRITE / SET / CLR on channel 0.
        e.d[0] = 16'h0F00; e.rd = 16'h0000; e.h = 1'b1;
        cyc(15'h7000, 16'h0F00, 1'b1);
        e.d[0] = 16'h0FF0; e.rd = 16'h0F00; e.h = 1'b1;
        cyc(15'h7001, 16'h00F0, 1'b1);
        e.d[0] = 16'h0CF0; e.rd = 16'h0FF0; e.h = 1'b1;
        cyc(15'h7002, 16'h0300, 1'b1);

        // Out of range (one past the top, one below base) and we=0 in range.
        e.rd = 16'h0000; e.h = 1'b0;
        cyc(15'h7010, 16'hFFFF, 1'b1);
        cyc(15'h6FFF, 16'hFFFF, 1'b1);
        e.rd = 16'h0CF0; e.h = 1'b1;
        cyc(15'h7000, 16'h1234, 1'b0);

        // Single pulse on channel 2: high for exactly 5 edges.
        e.d[2] = 16'h0001; e.b[2] = 1'b1; e.rd = 16'h0000; e.h = 1'b1;
        cyc(15'h700B, 16'h0001, 1'b1);
        idle(4);
        e.d[2] = 16'h0000; e.b[2] = 1'b0;
        idle(2);

        // Retrigger three edges in: five more cycles from the retrigger.
        e.d[2] = 16'h0002; e.b[2] = 1'b1; e.rd = 16'h0000; e.h = 1'b1;
        cyc(15'h700B, 16'h0002, 1'b1);
        idle(2);
        e.d[2] = 16'h0004; e.rd = 16'h0002; e.h = 1'b1;
        cyc(15'h700B, 16'h0004, 1'b1);
        idle(4);
        e.d[2] = 16'h0000; e.b[2] = 1'b0;
        idle(1);

        // WRITE lands on the expiry edge of channel 3: write wins.
        e.d[3] = 16'h00FF; e.b[3] = 1'b1; e.rd = 16'h0000; e.h = 1'b1;
        cyc(15'h700F, 16'h00FF, 1'b1);
        idle(4);
        e.d[3] = 16'hBEEF; e.b[3] = 1'b0; e.rd = 16'h00FF; e.h = 1'b1;
        cyc(15'h700C, 16'hBEEF, 1'b1);
        idle(2);

        // SET mid-pulse cancels it and ORs into the pulse value.
        e.d[1] = 16'h0010; e.b[1] = 1'b1; e.rd = 16'hA5A5; e.h = 1'b1;
        cyc(15'h7007, 16'h0010, 1'b1);
        idle(1);
        e.d[1] = 16'h0011; e.b[1] = 1'b0; e.rd = 16'h0010; e.h = 1'b1;
        cyc(15'h7005, 16'h0001, 1'b1);
        idle(5);

        // Async reset mid-pulse on channel 2.
        e.d[2] = 16'h00AA; e.b[2] = 1'b1; e.rd = 16'h0000; e.h = 1'b1;
        cyc(15'h700B, 16'h00AA, 1'b1);
        idle(1);
        @(negedge clk50m);
        #2;
        rst_n = 1'b0;
        #1;
        clear_exp();
        step++;
        e.id = step;
        check_all(e);
        idle(2);
        @(negedge clk50m);
        rst_n = 1'b1;
        idle(7);

        // Normal operation resumes.
        e.d[0] = 16'h0055; e.rd = 16'h0000; e.h = 1'b1;
        cyc(15'h7000, 16'h0055, 1'b1);
        idle(1);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk50m);
        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
